// File: rtl/uart_rx.sv
// UART receiver: start bit, Word_len data bits LSB first, one stop bit, no parity.
// Samples each bit at its centre and hands words out on a valid/ready stream.
module uart_rx #(
  parameter int unsigned clk_rate = 100000000,
  parameter int unsigned Baud     = 115200,
  parameter int unsigned Word_len = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                Uart_rx,
  output logic [Word_len-1:0] rx_data,
  output logic                rx_data_valid,
  input  logic                rx_data_ready,
  output logic                frame_err,
  output logic                overrun_err,
  output logic                rx_busy
);

  localparam int unsigned BAUD_DIV = clk_rate / Baud;
  localparam int unsigned HALF_DIV = BAUD_DIV / 2;
  localparam int unsigned CNT_W    = $clog2(BAUD_DIV) + 1;
  localparam int unsigned BIT_W    = $clog2(Word_len + 1);

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(Word_len - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_e;

  state_e              state_q;
  logic [1:0]          sync_q;
  logic [CNT_W-1:0]    baud_cnt_q;
  logic [BIT_W-1:0]    bit_cnt_q;
  logic [Word_len-1:0] shift_q;
  logic [Word_len-1:0] rx_data_q;
  logic                rx_data_valid_q;
  logic                frame_err_q;
  logic                overrun_err_q;
  logic                rx_busy_q;
  logic                rx_s;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], Uart_rx};
    end
  end

  assign rx_s = sync_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      baud_cnt_q      <= '0;
      bit_cnt_q       <= '0;
      shift_q         <= '0;
      rx_data_q       <= '0;
      rx_data_valid_q <= 1'b0;
      frame_err_q     <= 1'b0;
      overrun_err_q   <= 1'b0;
      rx_busy_q       <= 1'b0;
    end else begin
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
      // Consumer handshake; a delivery later in this block overrides the clear.
      if (rx_data_valid_q && rx_data_ready) begin
        rx_data_valid_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          baud_cnt_q <= '0;
          bit_cnt_q  <= '0;
          if (!rx_s) begin
            state_q   <= ST_START;
            rx_busy_q <= 1'b1;
          end
        end

        ST_START: begin
          if (baud_cnt_q == HALF_LAST) begin
            baud_cnt_q <= '0;
            if (rx_s) begin
              state_q   <= ST_IDLE;
              rx_busy_q <= 1'b0;
            end else begin
              state_q <= ST_DATA;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + CNT_W'(1);
          end
        end

        ST_DATA: begin
          if (baud_cnt_q == BAUD_LAST) begin
            baud_cnt_q <= '0;
            shift_q    <= {rx_s, shift_q[Word_len-1:1]};
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_q <= '0;
              state_q   <= ST_STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + BIT_W'(1);
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + CNT_W'(1);
          end
        end

        // Leaving at mid-stop-bit lets an immediately following start edge be caught.
        ST_STOP: begin
          if (baud_cnt_q == BAUD_LAST) begin
            baud_cnt_q <= '0;
            if (rx_s) begin
              state_q   <= ST_IDLE;
              rx_busy_q <= 1'b0;
              if (!rx_data_valid_q || rx_data_ready) begin
                rx_data_q       <= shift_q;
                rx_data_valid_q <= 1'b1;
              end else begin
                overrun_err_q <= 1'b1;
              end
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= ST_BREAK;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + CNT_W'(1);
          end
        end

        ST_BREAK: begin
          if (rx_s) begin
            state_q   <= ST_IDLE;
            rx_busy_q <= 1'b0;
          end
        end

        default: begin
          state_q   <= ST_IDLE;
          rx_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_data_valid = rx_data_valid_q;
  assign frame_err     = frame_err_q;
  assign overrun_err   = overrun_err_q;
  assign rx_busy       = rx_busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit; a negedge monitor
// collects accepted words and error pulses, each task compares against its own expectations.
module tb_uart_rx;

  localparam int unsigned BIT_T   = 16;
  localparam int unsigned LATENCY = 2 + 1 + BIT_T / 2 + 8 * BIT_T + BIT_T;

  logic       clk;
  logic       rst;
  logic       line;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rx_data_ready;
  logic       frame_err;
  logic       overrun_err;
  logic       rx_busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] got_q[$];
  int n_ferr, n_oerr, n_vrise, n_vcyc, n_both;
  int vrise_cyc, oerr_cyc, fall_cyc;
  logic prev_valid;

  uart_rx #(
    .clk_rate(1600),
    .Baud    (100),
    .Word_len(8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .Uart_rx      (line),
    .rx_data      (rx_data),
    .rx_data_valid(rx_data_valid),
    .rx_data_ready(rx_data_ready),
    .frame_err    (frame_err),
    .overrun_err  (overrun_err),
    .rx_busy      (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observation happens mid-cycle; a word seen with valid&ready is taken at the next edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (rx_data_valid && rx_data_ready) got_q.push_back(rx_data);
      if (rx_data_valid) n_vcyc++;
      if (rx_data_valid && !prev_valid) begin
        n_vrise++;
        vrise_cyc = cyc;
      end
      if (frame_err) n_ferr++;
      if (overrun_err) begin
        n_oerr++;
        oerr_cyc = cyc;
      end
      if (frame_err && overrun_err) n_both++;
      prev_valid = rx_data_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_mon();
    got_q.delete();
    n_ferr  = 0;
    n_oerr  = 0;
    n_vrise = 0;
    n_vcyc  = 0;
    vrise_cyc = -1;
    oerr_cyc  = -1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    line = 1'b0;
    fall_cyc = cyc;
    repeat (BIT_T) tick();
    for (int i = 0; i < 8; i++) begin
      line = d[i];
      repeat (BIT_T) tick();
    end
    line = stop_b;
    repeat (BIT_T) tick();
    line = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    line = 1'b1;
    rx_data_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", rx_data); end
    checks++; if (rx_data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rx_data_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b exp 0", frame_err); end
    checks++; if (overrun_err !== 1'b0) begin errors++; $display("FAIL reset_oerr got %b exp 0", overrun_err); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", rx_busy); end
    tick();
    rst = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_single();
    int lat;
    clear_mon();
    rx_data_ready = 1'b1;
    send_frame(8'hA5, 1'b1);
    repeat (20) tick();
    lat = vrise_cyc - fall_cyc;
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL single_count got %0d exp 1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== 8'hA5) begin errors++; $display("FAIL single_data got %h exp a5", got_q[0]); end
    end
    checks++; if (lat < int'(LATENCY) - 1 || lat > int'(LATENCY) + 1) begin errors++; $display("FAIL single_latency got %0d exp %0d+-1", lat, LATENCY); end
    checks++; if (n_vcyc !== 1) begin errors++; $display("FAIL single_valid_cycles got %0d exp 1", n_vcyc); end
    checks++; if (n_ferr + n_oerr !== 0) begin errors++; $display("FAIL single_errs got %0d exp 0", n_ferr + n_oerr); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    clear_mon();
    exp_q = '{8'h00, 8'hFF, 8'h3C};
    rx_data_ready = 1'b1;
    foreach (exp_q[i]) send_frame(exp_q[i], 1'b1);
    repeat (20) tick();
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL b2b_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    else begin
      foreach (exp_q[i]) begin
        checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_data[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
      end
    end
    checks++; if (n_vrise !== 3) begin errors++; $display("FAIL b2b_valid_pulses got %0d exp 3", n_vrise); end
    checks++; if (n_ferr + n_oerr !== 0) begin errors++; $display("FAIL b2b_errs got %0d exp 0", n_ferr + n_oerr); end
  endtask

  task automatic test_overrun();
    int f2;
    clear_mon();
    rx_data_ready = 1'b0;
    send_frame(8'h12, 1'b1);
    repeat (5) tick();
    send_frame(8'h34, 1'b1);
    f2 = fall_cyc;
    repeat (20) tick();
    @(negedge clk);
    checks++; if (rx_data !== 8'h12) begin errors++; $display("FAIL ovr_hold_data got %h exp 12", rx_data); end
    checks++; if (rx_data_valid !== 1'b1) begin errors++; $display("FAIL ovr_hold_valid got %b exp 1", rx_data_valid); end
    checks++; if (n_oerr !== 1) begin errors++; $display("FAIL ovr_pulses got %0d exp 1", n_oerr); end
    checks++; if (oerr_cyc - f2 < int'(LATENCY) - 1 || oerr_cyc - f2 > int'(LATENCY) + 1) begin errors++; $display("FAIL ovr_timing got %0d exp %0d+-1", oerr_cyc - f2, LATENCY); end
    checks++; if (n_ferr !== 0) begin errors++; $display("FAIL ovr_ferr got %0d exp 0", n_ferr); end
    tick();
    rx_data_ready = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    checks++; if (rx_data_valid !== 1'b0) begin errors++; $display("FAIL ovr_accept_valid got %b exp 0", rx_data_valid); end
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL ovr_accept_count got %0d exp 1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== 8'h12) begin errors++; $display("FAIL ovr_accept_data got %h exp 12", got_q[0]); end
    end
    tick();
  endtask

  task automatic test_break();
    clear_mon();
    rx_data_ready = 1'b1;
    send_frame(8'h55, 1'b0);
    line = 1'b0;
    repeat (40 * BIT_T) tick();
    @(negedge clk);
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL brk_busy_low got %b exp 1", rx_busy); end
    checks++; if (n_ferr !== 1) begin errors++; $display("FAIL brk_ferr_pulses got %0d exp 1", n_ferr); end
    checks++; if (n_vrise !== 0) begin errors++; $display("FAIL brk_valid got %0d exp 0", n_vrise); end
    tick();
    line = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL brk_busy_release got %b exp 0", rx_busy); end
    tick();
    clear_mon();
    send_frame(8'h66, 1'b1);
    repeat (20) tick();
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL brk_next_count got %0d exp 1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== 8'h66) begin errors++; $display("FAIL brk_next_data got %h exp 66", got_q[0]); end
    end
    checks++; if (n_ferr + n_oerr !== 0) begin errors++; $display("FAIL brk_next_errs got %0d exp 0", n_ferr + n_oerr); end
  endtask

  task automatic test_glitch();
    int busy_seen;
    clear_mon();
    busy_seen = 0;
    line = 1'b0;
    repeat (4) tick();
    line = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rx_busy === 1'b1) busy_seen++;
    end
    @(negedge clk);
    checks++; if (busy_seen == 0) begin errors++; $display("FAIL glitch_busy_seen got %0d exp >0", busy_seen); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end got %b exp 0", rx_busy); end
    checks++; if (n_vrise + n_ferr + n_oerr !== 0) begin errors++; $display("FAIL glitch_events got %0d exp 0", n_vrise + n_ferr + n_oerr); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    d = 8'hF8 | 8'($urandom_range(0, 7));
    clear_mon();
    rx_data_ready = 1'b1;
    line = 1'b0;
    repeat (BIT_T) tick();
    for (int i = 0; i < 3; i++) begin
      line = d[i];
      repeat (BIT_T) tick();
    end
    line = d[3];
    repeat (BIT_T / 2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rstmid_data got %h exp 00", rx_data); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", rx_busy); end
    checks++; if (rx_data_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", rx_data_valid); end
    repeat (BIT_T / 2 - 1) tick();
    for (int i = 4; i < 8; i++) begin
      line = d[i];
      repeat (BIT_T) tick();
    end
    line = 1'b1;
    repeat (BIT_T + 20) tick();
    checks++; if (n_vrise + n_ferr + n_oerr !== 0) begin errors++; $display("FAIL rstmid_tail_events got %0d exp 0", n_vrise + n_ferr + n_oerr); end
    clear_mon();
    send_frame(8'h81, 1'b1);
    repeat (20) tick();
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL rstmid_next_count got %0d exp 1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== 8'h81) begin errors++; $display("FAIL rstmid_next_data got %h exp 81", got_q[0]); end
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] d;
    clear_mon();
    rx_data_ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      d = 8'($urandom());
      exp_q.push_back(d);
      send_frame(d, 1'b1);
      repeat ($urandom_range(0, 20)) tick();
    end
    repeat (20) tick();
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    else begin
      foreach (exp_q[i]) begin
        checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_data[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
      end
    end
    checks++; if (n_ferr + n_oerr !== 0) begin errors++; $display("FAIL rand_errs got %0d exp 0", n_ferr + n_oerr); end
  endtask

  initial begin
    n_both = 0;
    prev_valid = 1'b0;
    clear_mon();
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_break();
    test_glitch();
    test_reset_mid();
    test_random();
    checks++; if (n_both !== 0) begin errors++; $display("FAIL both_errs_same_cycle got %0d exp 0", n_both); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
